// File: rtl/fact_pkg.sv
// Shared types and default widths for the factorial scheduler slice.
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    CAPTURE,
    RESP
  } sched_state_t;

  localparam int unsigned FACT_NW    = 4;
  localparam int unsigned FACT_RW    = 32;
  // Largest operand whose factorial fits in FACT_RW bits.
  localparam int unsigned FACT_N_MAX = 12;

endpackage

// File: rtl/fact_rr_arb.sv
// Combinational round-robin pick: search starts one past the pointer.
module fact_rr_arb
  import fact_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Walk requesters ptr+1 .. ptr+NREQ (mod NREQ) and take the first active one.
  always_comb begin
    int unsigned cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fact_sched.sv
// Shares one factorial engine between NREQ requesters with a watchdog.
module fact_sched
  import fact_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned NW      = FACT_NW,
  parameter int unsigned RW      = FACT_RW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  resp_valid,
  output logic [RW-1:0]    resp_result,
  output logic             resp_err,
  output logic             resp_tmo,
  output logic             busy,
  output logic             eng_go,
  output logic [NW-1:0]    eng_n,
  input  logic             eng_done,
  input  logic             eng_err,
  input  logic [RW-1:0]    eng_result
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  sched_state_t  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [NW-1:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic [NW-1:0]   sel_n;

  fact_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Operand slice of the arbitration winner.
  always_comb begin
    sel_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) sel_n = req_n[i*NW +: NW];
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    gnt         = '0;
    resp_valid  = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    resp_tmo    = 1'b0;
    eng_go      = 1'b0;
    busy        = (state_q != IDLE);
    eng_n       = (state_q != IDLE) ? op_q : '0;

    case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is held so no pulse escapes.
        if (rst && arb_valid) begin
          gnt     = arb_gnt;
          ptr_d   = arb_idx;
          id_d    = arb_idx;
          op_d    = sel_n;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        eng_go = 1'b1;
        if (eng_done && eng_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (eng_done) begin
          state_d = CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      CAPTURE: begin
        res_d   = eng_result;
        state_d = RESP;
      end
      RESP: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          resp_valid[i] = (id_q == IW'(i));
        end
        resp_result = (err_q || tmo_q) ? '0 : res_q;
        resp_err    = err_q;
        resp_tmo    = tmo_q;
        err_d       = 1'b0;
        tmo_d       = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched with a behavioural factorial engine.
module tb_fact_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [7:0]  req_n = '0;
  logic [1:0]  gnt;
  logic [1:0]  resp_valid;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        resp_tmo;
  logic        busy;
  logic        eng_go;
  logic [3:0]  eng_n;
  logic        eng_done;
  logic        eng_err;
  logic [31:0] eng_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fact_sched #(
    .NREQ    (2),
    .NW      (4),
    .RW      (32),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_n       (req_n),
    .gnt         (gnt),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .resp_tmo    (resp_tmo),
    .busy        (busy),
    .eng_go      (eng_go),
    .eng_n       (eng_n),
    .eng_done    (eng_done),
    .eng_err     (eng_err),
    .eng_result  (eng_result)
  );

  // Engine model: done low for eng_lat cycles after go, error on n > 12.
  logic       eng_busy = 1'b0;
  int         eng_cnt  = 0;
  int         eng_lat  = 3;
  logic [3:0] eng_nl   = '0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  assign eng_done   = !eng_busy;
  assign eng_err    = eng_go && !eng_busy && (eng_n > 4'd12);
  assign eng_result = fact(eng_nl);

  always @(posedge clk) begin
    if (eng_go) begin
      eng_nl <= eng_n;
      if (!eng_err) begin
        eng_busy <= 1'b1;
        eng_cnt  <= eng_lat;
      end
    end else if (eng_busy) begin
      if (eng_cnt == 1) eng_busy <= 1'b0;
      eng_cnt <= eng_cnt - 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic test_reset();
    req   = 2'b11;
    req_n = {4'd2, 4'd3};
    rst   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if ({resp_valid, resp_err, resp_tmo, eng_go, eng_n, resp_result} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: rv=%b err=%b tmo=%b go=%b n=%0d res=%0d expected all 0",
                 resp_valid, resp_err, resp_tmo, eng_go, eng_n, resp_result);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 01", gnt); end
    @(negedge clk); #1;
    n_checks++;
    if (eng_go !== 1'b1 || eng_n !== 4'd3) begin
      n_fail++; $display("FAIL reset_launch: go=%b n=%0d expected go=1 n=3", eng_go, eng_n);
    end
    req = 2'b00;
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || eng_n !== 4'd0) begin
      n_fail++; $display("FAIL reset_abort: busy=%b n=%0d expected 0 0", busy, eng_n);
    end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (resp_valid !== 2'b00 || gnt !== 2'b00) begin
        n_fail++; $display("FAIL reset_no_resp: rv=%b gnt=%b expected 00 00", resp_valid, gnt);
      end
    end
  endtask

  task automatic run_job(input int id, input int n, input int lat,
                         input logic [31:0] exp_res, input logic exp_err,
                         input logic exp_tmo, input int exp_lat, input string tag);
    int waited;
    int t;
    logic [3:0] nv;
    nv      = 4'(n);
    eng_lat = lat;
    @(negedge clk);
    req            = 2'b00;
    req[id]        = 1'b1;
    req_n[id*4 +: 4] = nv;
    #1;
    waited = 0;
    while (gnt === 2'b00 && waited < 20) begin @(negedge clk); #1; waited++; end
    n_checks++;
    if (gnt !== 2'(1 << id)) begin
      n_fail++; $display("FAIL %s_gnt: got %b expected %b", tag, gnt, 2'(1 << id));
    end
    @(negedge clk);
    req[id] = 1'b0;
    #1;
    t = 1;
    n_checks++;
    if (eng_go !== 1'b1 || eng_n !== nv) begin
      n_fail++; $display("FAIL %s_launch: go=%b n=%0d expected go=1 n=%0d", tag, eng_go, eng_n, nv);
    end
    while (resp_valid === 2'b00 && t < 200) begin @(negedge clk); #1; t++; end
    n_checks++;
    if (t != exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected %0d", tag, t, exp_lat);
    end
    n_checks++;
    if (resp_valid !== 2'(1 << id)) begin
      n_fail++; $display("FAIL %s_resp_valid: got %b expected %b", tag, resp_valid, 2'(1 << id));
    end
    n_checks++;
    if (resp_result !== exp_res || resp_err !== exp_err || resp_tmo !== exp_tmo) begin
      n_fail++;
      $display("FAIL %s_resp: res=%0d err=%b tmo=%b expected res=%0d err=%b tmo=%b",
               tag, resp_result, resp_err, resp_tmo, exp_res, exp_err, exp_tmo);
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || eng_n !== 4'd0) begin
      n_fail++; $display("FAIL %s_idle: busy=%b rv=%b n=%0d expected 0 00 0", tag, busy, resp_valid, eng_n);
    end
  endtask

  task automatic test_single();
    run_job(0, 5, 3, 32'd120, 1'b0, 1'b0, 7, "single_n5");
    run_job(0, 0, 3, 32'd1, 1'b0, 1'b0, 7, "single_n0");
    run_job(0, 12, 5, 32'd479001600, 1'b0, 1'b0, 9, "single_n12");
  endtask

  task automatic test_range_error();
    run_job(1, 13, 3, 32'd0, 1'b1, 1'b0, 2, "range_err");
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] exp_g;
    int waited;
    eng_lat = 2;
    @(negedge clk);
    req   = 2'b11;
    req_n = {4'd3, 4'd3};
    for (int j = 0; j < 4; j++) begin
      #1;
      waited = 0;
      while (gnt === 2'b00 && waited < 20) begin @(negedge clk); #1; waited++; end
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      g = gnt;
      n_checks++;
      if (g !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", j, g, exp_g); end
      @(negedge clk);
      if (j == 3) req = 2'b00;
      #1;
      waited = 0;
      while (resp_valid === 2'b00 && waited < 50) begin @(negedge clk); #1; waited++; end
      n_checks++;
      if (resp_valid !== exp_g || resp_result !== 32'd6) begin
        n_fail++; $display("FAIL rr_resp%0d: rv=%b res=%0d expected %b 6", j, resp_valid, resp_result, exp_g);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    run_job(0, 7, 200, 32'd0, 1'b0, 1'b1, 66, "timeout");
    run_job(1, 4, 3, 32'd24, 1'b0, 1'b0, 7, "after_tmo");
  endtask

  task automatic test_collisions();
    int seen;
    int waited;
    run_job(0, 6, 63, 32'd720, 1'b0, 1'b0, 67, "done_at_limit");
    eng_lat = 50;
    @(negedge clk);
    req   = 2'b10;
    req_n = {4'd4, 4'd0};
    #1;
    waited = 0;
    while (gnt === 2'b00 && waited < 20) begin @(negedge clk); #1; waited++; end
    n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL busy_reset_gnt: got %b expected 10", gnt); end
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || eng_go !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_pre: busy=%b go=%b expected 1 0", busy, eng_go);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || eng_n !== 4'd0) begin
      n_fail++; $display("FAIL busy_reset_idle: busy=%b rv=%b n=%0d expected 0 00 0", busy, resp_valid, eng_n);
    end
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk); #1;
      if (resp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL busy_reset_quiet: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_range_error();
    test_round_robin();
    test_timeout();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
